// File: rtl/remote_cmd_link.sv
// Host end of the robot command link: 16-bit command out as two 8N1 bytes (high first),
// 8-bit response in with a ready flag; TX and RX are independent full-duplex engines.
module remote_cmd_link #(
  parameter int BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        snd_cmd,
  input  logic [15:0] cmd,
  output logic        busy,
  output logic        cmd_snt,
  output logic        TX,
  input  logic        RX,
  output logic [7:0]  resp,
  output logic        resp_rdy,
  input  logic        clr_resp_rdy
);

  localparam int CW = ($clog2(BAUD_DIV) < 12) ? 12 : $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BIT_END  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_END = CW'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, SEND_HI, SEND_LO} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  tx_state_t     tx_state, tx_next;
  logic [15:0]   shadow;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bit;
  logic          tx_bit_end, tx_frame_end;
  logic [7:0]    tx_byte;

  assign tx_bit_end   = (tx_cnt == BIT_END);
  assign tx_frame_end = tx_bit_end && (tx_bit == 4'd9);
  assign tx_byte      = (tx_state == SEND_HI) ? shadow[15:8] : shadow[7:0];
  assign busy         = (tx_state != TX_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_state <= TX_IDLE;
    else        tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE: if (snd_cmd)      tx_next = SEND_HI;
      SEND_HI: if (tx_frame_end) tx_next = SEND_LO;
      SEND_LO: if (tx_frame_end) tx_next = TX_IDLE;
      default:                   tx_next = TX_IDLE;
    endcase
  end

  // TX always carries the bit now being sent; the start bit is loaded on the accept
  // edge and the low byte's start bit directly replaces the high byte's stop bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow  <= '0;
      tx_cnt  <= '0;
      tx_bit  <= '0;
      TX      <= 1'b1;
      cmd_snt <= 1'b0;
    end else if (tx_state == TX_IDLE) begin
      if (snd_cmd) begin
        shadow  <= cmd;
        cmd_snt <= 1'b0;
        TX      <= 1'b0;
        tx_cnt  <= '0;
        tx_bit  <= '0;
      end
    end else if (!tx_bit_end) begin
      tx_cnt <= tx_cnt + CW'(1);
    end else begin
      tx_cnt <= '0;
      if (tx_bit == 4'd9) begin
        tx_bit <= '0;
        if (tx_state == SEND_HI) begin
          TX <= 1'b0;
        end else begin
          TX      <= 1'b1;
          cmd_snt <= 1'b1;
        end
      end else begin
        tx_bit <= tx_bit + 4'd1;
        TX     <= (tx_bit == 4'd8) ? 1'b1 : tx_byte[tx_bit[2:0]];
      end
    end
  end

  rx_state_t     rx_state, rx_next;
  logic [1:0]    rx_sync;
  logic          rx_s, rx_d;
  logic [CW-1:0] rx_cnt;
  logic [3:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_half, rx_full, rx_set, rx_confirm;

  assign rx_s       = rx_sync[1];
  assign rx_half    = (rx_cnt == HALF_END);
  assign rx_full    = (rx_cnt == BIT_END);
  assign rx_confirm = (rx_state == RX_START) && rx_half && !rx_s;
  assign rx_set     = (rx_state == RX_STOP) && rx_full && rx_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_state <= RX_IDLE;
    else        rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_d && !rx_s)                rx_next = RX_START;
      RX_START: if (rx_half)                      rx_next = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_full && rx_bit == 4'd7)    rx_next = RX_STOP;
      RX_STOP:  if (rx_full)                      rx_next = RX_IDLE;
      default:                                    rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync  <= 2'b11;
      rx_d     <= 1'b1;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_sync <= {rx_sync[0], RX};
      rx_d    <= rx_s;
      case (rx_state)
        RX_START: rx_cnt <= rx_half ? '0 : rx_cnt + CW'(1);
        RX_DATA: begin
          if (rx_full) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s, rx_shift[7:1]};
            rx_bit   <= rx_bit + 4'd1;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        RX_STOP: rx_cnt <= rx_cnt + CW'(1);
        default: begin
          rx_cnt <= '0;
          rx_bit <= '0;
        end
      endcase
    end
  end

  // A new byte landing in the same cycle as the host acknowledge must not be lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp     <= '0;
      resp_rdy <= 1'b0;
    end else if (rx_set) begin
      resp     <= rx_shift;
      resp_rdy <= 1'b1;
    end else if (clr_resp_rdy || rx_confirm) begin
      resp_rdy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_remote_cmd_link.sv
// Bench for remote_cmd_link at 16 clocks/bit: TX bitstream and RX response checked
// against a frame-level model, with directed cases followed by randomized full-duplex traffic.
module tb_remote_cmd_link;
  localparam int BD   = 16;
  localparam int LAST = 20 * BD + 1;

  logic        clk = 1'b0;
  logic        rst_n, snd_cmd, rx_line, clr_man, clr_auto, auto_clr;
  logic [15:0] cmd;
  logic        busy, cmd_snt, tx_line, resp_rdy, clr_resp_rdy;
  logic [7:0]  resp;
  logic [7:0]  exp_resp;
  logic        exp_rdy;
  int          n_checks = 0;
  int          n_errors = 0;

  assign clr_resp_rdy = clr_man | clr_auto;

  remote_cmd_link #(.BAUD_DIV(BD)) dut (
    .clk(clk), .rst_n(rst_n), .snd_cmd(snd_cmd), .cmd(cmd), .busy(busy),
    .cmd_snt(cmd_snt), .TX(tx_line), .RX(rx_line), .resp(resp),
    .resp_rdy(resp_rdy), .clr_resp_rdy(clr_resp_rdy)
  );

  always #5 clk = ~clk;

  // Acknowledge whenever nothing is pending, so the acknowledge lands on the set cycle.
  always @(negedge clk) clr_auto = auto_clr && !resp_rdy;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected TX level in cycle c after the accept cycle: 20 frame bits of BD clocks each.
  function automatic logic exp_tx(input logic [15:0] v, input int c);
    int idx, k;
    logic [7:0] b;
    idx = (c - 1) / BD;
    if (idx >= 20) return 1'b1;
    b = (idx < 10) ? v[15:8] : v[7:0];
    k = idx % 10;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k-1];
  endfunction

  task automatic tx_frame(input logic [15:0] val, input bit pre_started, input int inj_cyc,
                          input logic [15:0] inj_cmd, input int rst_cyc, input bit chain,
                          input logic [15:0] nxt);
    if (!pre_started) begin
      @(negedge clk);
      snd_cmd = 1'b1;
      cmd     = val;
    end
    for (int c = 1; c <= LAST; c++) begin
      @(negedge clk);
      check("tx_line", 32'(tx_line), 32'(exp_tx(val, c)));
      check("busy", 32'(busy), 32'(c < LAST));
      check("cmd_snt", 32'(cmd_snt), 32'(c == LAST));
      if (c == rst_cyc) begin
        snd_cmd = 1'b0;
        rst_n   = 1'b0;
        #1;
        check("rst_tx", 32'(tx_line), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cmd_snt", 32'(cmd_snt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      snd_cmd = (c == inj_cyc);
      cmd     = (c == inj_cyc) ? inj_cmd : 16'($urandom);
      if (c == LAST && chain) begin
        snd_cmd = 1'b1;
        cmd     = nxt;
      end
    end
    if (!chain) begin
      @(negedge clk);
      snd_cmd = 1'b0;
      check("tx_idle", 32'(tx_line), 32'd1);
    end
  endtask

  task automatic rx_byte(input logic [7:0] d, input logic stop_bit);
    logic [9:0] fr;
    fr = {stop_bit, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < BD; j++) begin
        @(negedge clk);
        rx_line = fr[i];
        if (i == 9 && j == BD / 2 + 3) begin
          if (stop_bit) begin
            exp_resp = d;
            exp_rdy  = 1'b1;
          end else begin
            exp_rdy = 1'b0;
          end
          check("rx_resp", 32'(resp), 32'(exp_resp));
          check("rx_rdy", 32'(resp_rdy), 32'(exp_rdy));
        end
      end
    end
    repeat (4) @(negedge clk) rx_line = 1'b1;
  endtask

  initial begin
    logic [15:0] rv;
    logic [7:0]  rb;
    rst_n = 1'b0; snd_cmd = 1'b0; cmd = '0; rx_line = 1'b1;
    clr_man = 1'b0; auto_clr = 1'b0;
    exp_resp = 8'h00; exp_rdy = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_tx", 32'(tx_line), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_cmd_snt", 32'(cmd_snt), 32'd0);
    check("reset_resp", 32'(resp), 32'h00);
    check("reset_rdy", 32'(resp_rdy), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Busy-time snd_cmd must be ignored; second frame is accepted on the cmd_snt cycle.
    tx_frame(16'hA5C3, 1'b0, 100, 16'h1234, -1, 1'b1, 16'h00FF);
    tx_frame(16'h00FF, 1'b1, -1, 16'h0000, -1, 1'b0, 16'h0000);

    rx_byte(8'h5A, 1'b1);
    repeat (4) @(negedge clk) rx_line = 1'b0;
    rx_line = 1'b1;
    repeat (12 * BD) @(negedge clk);
    check("glitch_resp", 32'(resp), 32'(exp_resp));
    check("glitch_rdy", 32'(resp_rdy), 32'(exp_rdy));
    @(negedge clk) clr_man = 1'b1;
    @(negedge clk) clr_man = 1'b0;
    exp_rdy = 1'b0;
    @(negedge clk);
    check("clr_rdy", 32'(resp_rdy), 32'(exp_rdy));
    check("clr_resp", 32'(resp), 32'(exp_resp));

    rx_byte(8'h3C, 1'b0);
    repeat (BD) @(negedge clk);
    check("frame_err_resp", 32'(resp), 32'h5A);
    check("frame_err_rdy", 32'(resp_rdy), 32'd0);

    auto_clr = 1'b1;
    rx_byte(8'h81, 1'b1);
    auto_clr = 1'b0;
    repeat (2) @(negedge clk);
    check("set_wins_rdy", 32'(resp_rdy), 32'd1);
    check("set_wins_resp", 32'(resp), 32'h81);

    fork
      tx_frame(16'hBEEF, 1'b0, -1, 16'h0000, -1, 1'b0, 16'h0000);
      begin
        repeat (40) @(negedge clk);
        rx_byte(8'h77, 1'b1);
      end
    join
    check("duplex_resp", 32'(resp), 32'h77);

    tx_frame(16'h1357, 1'b0, -1, 16'h0000, 200, 1'b0, 16'h0000);
    exp_resp = 8'h00;
    exp_rdy  = 1'b0;
    check("post_rst_resp", 32'(resp), 32'(exp_resp));
    check("post_rst_rdy", 32'(resp_rdy), 32'(exp_rdy));
    tx_frame(16'h2468, 1'b0, -1, 16'h0000, -1, 1'b0, 16'h0000);

    for (int it = 0; it < 4; it++) begin
      rv = 16'($urandom);
      rb = 8'($urandom);
      fork
        tx_frame(rv, 1'b0, int'($urandom_range(1, LAST - 1)), 16'($urandom), -1, 1'b0, 16'h0000);
        begin
          repeat ($urandom_range(1, 100)) @(negedge clk);
          rx_byte(rb, $urandom_range(0, 3) != 0);
        end
      join
      check("rand_resp", 32'(resp), 32'(exp_resp));
      check("rand_rdy", 32'(resp_rdy), 32'(exp_rdy));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
